// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator: MSB-first, CHUNK bits per clock, early exit.
// Optional signed mode (sgn port) is enabled by defining SIGNED_CMP_EN.
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
`ifdef SIGNED_CMP_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic             Greater,
  output logic             Equal,
  output logic             Less
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, CMP} state_t;
  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } res_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a, b, a_n, b_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  res_t             res, res_n;
  logic             done_n;
  logic [WIDTH-1:0] flip;
  logic [CHUNK-1:0] a_top, b_top;

  // Inverting both MSBs maps two's complement onto unsigned order.
`ifdef SIGNED_CMP_EN
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
  assign flip = sgn ? MSB : '0;
`else
  assign flip = '0;
`endif

  assign a_top = a[WIDTH-1 -: CHUNK];
  assign b_top = b[WIDTH-1 -: CHUNK];

  always_comb begin
    state_n = state;
    a_n     = a;
    b_n     = b;
    cnt_n   = cnt;
    res_n   = res;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          a_n     = in1 ^ flip;
          b_n     = in2 ^ flip;
          cnt_n   = CNT_W'(N - 1);
          state_n = CMP;
        end
      end
      CMP: begin
        if (a_top > b_top) begin
          res_n   = '{gt: 1'b1, eq: 1'b0, lt: 1'b0};
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (a_top < b_top) begin
          res_n   = '{gt: 1'b0, eq: 1'b0, lt: 1'b1};
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (cnt == '0) begin
          res_n   = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          a_n   = a << CHUNK;
          b_n   = b << CHUNK;
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      cnt   <= '0;
      res   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      a     <= a_n;
      b     <= b_n;
      cnt   <= cnt_n;
      res   <= res_n;
      done  <= done_n;
    end
  end

  assign busy    = (state == CMP);
  assign Greater = res.gt;
  assign Equal   = res.eq;
  assign Less    = res.lt;

endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Parametrised, multi-cycle magnitude comparator: the successor of the team's 2-bit combinational comparator, generalised to WIDTH-bit operands. It compares the operands MSB-first, CHUNK bits per clock, and terminates early at the first differing chunk. It reports Greater/Equal/Less with a start/done handshake. It sits beside datapath units that need wide compares without a long combinational carry chain.

## Interface
- WIDTH, 16: operand width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4: bits compared per cycle; N = WIDTH/CHUNK compare steps, N ≥ 1.
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; accepted only when busy=0.
- in1  input  WIDTH  operand A; sampled on the accepting edge only.
- in2  input  WIDTH  operand B; sampled on the accepting edge only.
- sgn  input  1  signed-compare select; exists only with SIGNED_CMP_EN.
- busy  output  1  compare in progress; start is ignored while high.
- done  output  1  one-cycle pulse when a result is registered.
- Greater  output  1  in1 > in2 for the last completed compare.
- Equal  output  1  in1 == in2 for the last completed compare.
- Less  output  1  in1 < in2 for the last completed compare.

## Operation
- States: IDLE and CMP.
- IDLE:
  - On start=1, latch in1/in2 into shift registers a/b, set busy=1, and go to CMP.
  - Load a step counter with N-1.
- CMP, each clock, compare the top CHUNK bits of a and b:
  - a_top > b_top: register Greater=1, Equal=0, Less=0; done=1, busy=0; go to IDLE.
  - a_top < b_top: register Less=1, Greater=0, Equal=0; done=1, busy=0; go to IDLE.
  - Equal with counter = 0: register Equal=1, Greater=0, Less=0; done=1, busy=0; go to IDLE.
  - Equal with counter > 0: shift a and b left by CHUNK, decrement the counter, stay in CMP.
- Result flags are one-hot after the first completed compare.
- Result flags hold their value until the next done. They never change while busy=1.
- The compare is unsigned unless signed mode is active (see Configuration).
- A start while busy=1 is ignored. It is not queued, and its operands are not sampled.
- Reset asserted mid-compare aborts immediately: no done pulse, all outputs take their reset values.

## Timing
- Reset values: busy=0, done=0, Greater=0, Equal=0, Less=0; state IDLE.
- Accept edge: busy=1 is visible in the following cycle.
- Latency: done rises k edges after the accept edge, where k is the 1-based index (MSB-first) of the first differing chunk. k=N if the operands are equal or differ only in the last chunk.
- Range: minimum latency 1, maximum N.
- done is high for exactly one cycle and coincides with the new result flags and busy=0.
- Back-to-back: start may be asserted in the cycle done=1. It is accepted on the next edge, giving no dead cycle between compares.
- With N=1 every compare completes in exactly 1 cycle.

## Configuration
- SIGNED_CMP_EN defined:
  - Port sgn is present.
  - On accept with sgn=1, the MSB of each latched operand is inverted. This maps two's complement onto unsigned order, so Greater/Less reflect signed magnitude.
  - sgn=0 gives an unsigned compare.
  - sgn is sampled only on the accept edge.
- SIGNED_CMP_EN undefined: port sgn is absent; all compares are unsigned.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
- in1=0xA000, in2=0x5000, start pulse: done 1 cycle after accept; Greater=1, Equal=0, Less=0.
- in1=0x1234, in2=0x1235: done 4 cycles after accept; Less=1. Then in1=in2=0xBEEF: done after 4 cycles; Equal=1.
- Back-to-back compare plus ignored start:
  - start held high across a compare: a second compare is accepted in the done cycle and completes with no dead cycle.
  - start pulsed while busy=1 with different operands: ignored; the result reflects the original operands only.
- SIGNED_CMP_EN defined, in1=0x8000, in2=0x0001:
  - sgn=1: Less=1 after 1 cycle.
  - sgn=0: Greater=1 after 1 cycle.
- rst_n pulled low 2 cycles into a 4-step compare (in1=0x1111, in2=0x1112):
  - All outputs go to 0 asynchronously; no done pulse.
  - After release, a fresh compare of 0x0002 vs 0x0001 gives Greater=1.
